// File: rtl/wisc_trace_pkg.sv
// Shared types for the WISC-S15 trace emitter: packet type codes, queued event
// record, serializer states and the header-word builder.
package wisc_trace_pkg;

    typedef enum logic [3:0] {
        TT_REG  = 4'h1,
        TT_BRT  = 4'h2,
        TT_BRN  = 4'h3,
        TT_CALL = 4'h4,
        TT_RET  = 4'h5,
        TT_HALT = 4'hF
    } trace_type_e;

    // nwords is the total packet length including the header (2 or 3)
    typedef struct packed {
        trace_type_e ttype;
        logic [11:0] info;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [1:0]  nwords;
    } trace_evt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY0,
        S_PAY1,
        S_DONE
    } ser_state_e;

    function automatic logic [15:0] header_word(input trace_evt_t e);
        return {e.ttype, e.info};
    endfunction

endpackage

// File: rtl/trace_evt_fifo.sv
// Event queue with two write ports (slot A lands before slot B) and one read port.
// The caller guarantees pushes never exceed free + pop.
module trace_evt_fifo
    import wisc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CNTW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_a,
    input  trace_evt_t       data_a,
    input  logic             push_b,
    input  trace_evt_t       data_b,
    input  logic             pop,
    output trace_evt_t       head,
    output logic             empty,
    output logic [CNTW-1:0]  free
);

    trace_evt_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   b_idx;
    logic [CNTW-1:0] count;

    assign b_idx = push_a ? wr_ptr + AW'(1) : wr_ptr;
    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign free  = CNTW'(DEPTH) - count;

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= data_a;
        if (push_b) mem[b_idx]  <= data_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CNTW'(push_a) + CNTW'(push_b) - CNTW'(pop);
        end
    end

endmodule

// File: rtl/trace_event_packer.sv
// Captures core register-write and PC-control events, queues them, and
// serializes each as a 2- or 3-word packet on a valid/ready trace stream.
module trace_event_packer
    import wisc_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [3:0]  reg_addr,
    input  logic [15:0] reg_data,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] pc_cur,
    input  logic [15:0] pc_target,
    input  logic        call,
    input  logic        ret,
    input  logic        halt,
    output logic [15:0] tr_data,
    output logic        tr_valid,
    input  logic        tr_ready,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic        done
);

    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   cycle;
    logic [31:0]     cyc32;
    logic            halted;
    trace_evt_t      evt_a, evt_b, head, cur;
    logic            want_a, want_b, push_a, push_b, pop, empty;
    logic [CNTW-1:0] free, free_eff, need;
    logic [2:0]      nctrl, ndrop;
    logic [8:0]      drop_sum;
    logic            hs, last;
    ser_state_e      state;

    assign cyc32 = 32'(cycle);
    assign hs    = tr_valid && tr_ready;
    assign last  = (state == S_PAY0 && cur.nwords == 2'd2) || state == S_PAY1;
    // An entry leaves the queue when its header is accepted, so a stalled sink keeps all DEPTH slots occupied
    assign pop   = (state == S_HDR) && hs;

    always_comb begin
        evt_a.ttype  = TT_REG;
        evt_a.info   = {8'h00, reg_addr};
        evt_a.p0     = reg_data;
        evt_a.p1     = '0;
        evt_a.nwords = 2'd2;

        evt_b.ttype  = TT_RET;
        evt_b.info   = '0;
        evt_b.p0     = pc_target;
        evt_b.p1     = '0;
        evt_b.nwords = 2'd2;
        if (halt) begin
            evt_b.ttype  = TT_HALT;
            evt_b.p0     = cyc32[31:16];
            evt_b.p1     = cyc32[15:0];
            evt_b.nwords = 2'd3;
        end else if (br_valid && br_taken) begin
            evt_b.ttype  = TT_BRT;
            evt_b.p0     = pc_cur;
            evt_b.p1     = pc_target;
            evt_b.nwords = 2'd3;
        end else if (br_valid) begin
            evt_b.ttype  = TT_BRN;
            evt_b.p0     = pc_cur;
        end else if (call) begin
            evt_b.ttype  = TT_CALL;
        end
    end

    // Admission: priority losers are always dropped; when space is short slot B goes before slot A
    always_comb begin
        want_a   = reg_we;
        nctrl    = {2'b00, halt} + {2'b00, br_valid} + {2'b00, call} + {2'b00, ret};
        want_b   = (nctrl != 3'd0);
        free_eff = free + CNTW'(pop);
        need     = CNTW'(want_a) + CNTW'(want_b);
        push_a   = 1'b0;
        push_b   = 1'b0;
        ndrop    = 3'd0;
        if (!halted) begin
            ndrop = want_b ? nctrl - 3'd1 : 3'd0;
            if (need <= free_eff) begin
                push_a = want_a;
                push_b = want_b;
            end else if (want_a && want_b && free_eff != '0) begin
                push_a = 1'b1;
                ndrop  = ndrop + 3'd1;
            end else begin
                ndrop  = ndrop + {2'b00, want_a} + {2'b00, want_b};
            end
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + {6'b000000, ndrop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle    <= '0;
            halted   <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            cycle    <= cycle + CW'(1);
            if (push_b && halt) halted <= 1'b1;
            if (ndrop != 3'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end
    end

    trace_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (push_a),
        .data_a (evt_a),
        .push_b (push_b),
        .data_b (evt_b),
        .pop    (pop),
        .head   (head),
        .empty  (empty),
        .free   (free)
    );

    // Serializer: the next header is loaded on the last payload handshake so packets run without bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cur      <= '0;
            tr_data  <= 16'h0000;
            tr_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur      <= head;
                        tr_data  <= header_word(head);
                        tr_valid <= 1'b1;
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (hs) begin
                        tr_data <= cur.p0;
                        state   <= S_PAY0;
                    end
                end
                S_PAY0, S_PAY1: begin
                    if (hs) begin
                        if (!last) begin
                            tr_data <= cur.p1;
                            state   <= S_PAY1;
                        end else if (cur.ttype == TT_HALT) begin
                            tr_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else if (!empty) begin
                            cur     <= head;
                            tr_data <= header_word(head);
                            state   <= S_HDR;
                        end else begin
                            tr_valid <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_event_packer.sv
// Scoreboard bench for trace_event_packer: expected words are queued when events
// are driven and compared against every accepted trace word.
module tb_trace_event_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_we = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [15:0] reg_data = '0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] pc_cur = '0;
    logic [15:0] pc_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] tr_data;
    logic        tr_valid;
    logic        tr_ready = 1'b0;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [31:0] cyc;

    trace_event_packer #(.DEPTH(8), .CW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .pc_cur    (pc_cur),
        .pc_target (pc_target),
        .call      (call),
        .ret       (ret),
        .halt      (halt),
        .tr_data   (tr_data),
        .tr_valid  (tr_valid),
        .tr_ready  (tr_ready),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference cycle counter, sampled by halt events at the edge that captures them
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 32'd0;
        else      cyc <= cyc + 32'd1;
    end

    // Handshake seen at the falling edge is the one that completes at the next rising edge
    always @(negedge clk) begin
        if (rst && tr_valid && tr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_word got %h required none", tr_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (tr_data !== e) begin
                    errors++;
                    $display("[TB] FAIL stream_word got %h required %h", tr_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        reg_we = 0; br_valid = 0; br_taken = 0; call = 0; ret = 0; halt = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        exp_q.delete();
        rst = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        step();
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b required 0", tr_valid); end
        checks++; if (tr_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data got %h required 0000", tr_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %b required 0", overflow); end
        checks++; if (drop_cnt !== 8'h00) begin errors++; $display("[TB] FAIL reset_drop_cnt got %h required 00", drop_cnt); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b required 0", done); end
        rst = 1'b1;
    endtask

    task automatic test_reg_write();
        bit ok;
        tr_ready = 1;
        reg_we = 1; reg_addr = 4'd3; reg_data = 16'hBEEF;
        exp_q.push_back(16'h1003); exp_q.push_back(16'hBEEF);
        step();
        clear_inputs();
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reg_latency_early got %b required 0", tr_valid); end
        step();
        checks++; if (tr_valid !== 1'b1 || tr_data !== 16'h1003) begin errors++; $display("[TB] FAIL reg_first_header got %b/%h required 1/1003", tr_valid, tr_data); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL reg_drain got %0d required 0", exp_q.size()); end
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reg_idle got %b required 0", tr_valid); end
    endtask

    task automatic test_back_to_back();
        int cnt = 0, first = -1, lastc = -1;
        tr_ready = 1;
        reg_we = 1; reg_addr = 4'd5; reg_data = 16'h0007;
        br_valid = 1; br_taken = 1; pc_cur = 16'h0010; pc_target = 16'h0042;
        exp_q.push_back(16'h1005); exp_q.push_back(16'h0007);
        exp_q.push_back(16'h2000); exp_q.push_back(16'h0010); exp_q.push_back(16'h0042);
        step();
        clear_inputs();
        for (int i = 0; i < 12; i++) begin
            step();
            if (tr_valid) begin
                cnt++;
                if (first < 0) first = i;
                lastc = i;
            end
        end
        checks++; if (cnt != 5 || lastc - first != 4) begin errors++; $display("[TB] FAIL b2b_span got %0d words over %0d cycles required 5 over 5", cnt, lastc - first + 1); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL b2b_drain got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        bit ok;
        tr_ready = 0;
        for (int i = 0; i < 10; i++) begin
            reg_we = 1; reg_addr = 4'(i); reg_data = 16'hA000 + 16'(i);
            if (i < 8) begin
                exp_q.push_back(16'h1000 | 16'(i));
                exp_q.push_back(16'hA000 + 16'(i));
            end
            step();
        end
        clear_inputs();
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b required 1", overflow); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("[TB] FAIL ovf_drop_cnt got %0d required 2", drop_cnt); end
        tr_ready = 1;
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_drain got %0d required 0", exp_q.size()); end
        step();
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_idle got %b required 0", tr_valid); end
    endtask

    task automatic test_priority();
        bit ok;
        tr_ready = 1;
        call = 1; ret = 1; pc_target = 16'h0100;
        exp_q.push_back(16'h4000); exp_q.push_back(16'h0100);
        step();
        clear_inputs();
        br_valid = 1; br_taken = 0; call = 1; pc_cur = 16'h0200; pc_target = 16'h0300;
        exp_q.push_back(16'h3000); exp_q.push_back(16'h0200);
        step();
        clear_inputs();
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL prio_drain got %0d required 0", exp_q.size()); end
        checks++; if (drop_cnt !== 8'd4) begin errors++; $display("[TB] FAIL prio_drop_cnt got %0d required 4", drop_cnt); end
    endtask

    task automatic test_stall();
        logic        prev_valid = 0, prev_hs = 0;
        logic [15:0] prev_data = '0;
        int          nhs = 0;
        tr_ready = 0;
        br_valid = 1; br_taken = 1; pc_cur = 16'h1234; pc_target = 16'h5678;
        exp_q.push_back(16'h2000); exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
        step();
        clear_inputs();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            tr_ready = (i % 2 == 1);
            if (prev_valid && !prev_hs) begin
                checks++;
                if (tr_valid !== 1'b1 || tr_data !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL stall_hold got %b/%h required 1/%h", tr_valid, tr_data, prev_data);
                end
            end
            prev_valid = tr_valid;
            prev_data  = tr_data;
            prev_hs    = tr_valid && tr_ready;
            if (prev_hs) nhs++;
            step();
        end
        tr_ready = 1;
        checks++; if (nhs != 3) begin errors++; $display("[TB] FAIL stall_words got %0d required 3", nhs); end
    endtask

    task automatic test_halt();
        bit ok;
        int n = 0;
        do_reset();
        tr_ready = 1;
        while (cyc != 32'd100 && n < 300) begin
            step();
            n++;
        end
        halt = 1;
        exp_q.push_back(16'hF000); exp_q.push_back(cyc[31:16]); exp_q.push_back(cyc[15:0]);
        step();
        clear_inputs();
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL halt_drain got %0d required 0", exp_q.size()); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL halt_done got %b required 1", done); end
        for (int i = 0; i < 4; i++) begin
            reg_we = 1; reg_addr = 4'd7; reg_data = 16'h1111;
            br_valid = 1; call = 1;
            step();
        end
        clear_inputs();
        repeat (4) step();
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_quiet got %b required 0", tr_valid); end
        checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL halt_no_drops got %0d/%b required 0/0", drop_cnt, overflow); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL halt_done_sticky got %b required 1", done); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        tr_ready = 0;
        for (int i = 0; i < 10; i++) begin
            reg_we = 1; reg_addr = 4'(i); reg_data = 16'(i);
            step();
        end
        clear_inputs();
        checks++; if (tr_valid !== 1'b1 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_state got %b/%b required 1/1", tr_valid, overflow); end
        rst = 1'b0;
        #1;
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_valid got %b required 0", tr_valid); end
        exp_q.delete();
        step();
        step();
        rst = 1'b1;
        tr_ready = 1;
        repeat (3) step();
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_queue_empty got %b required 0", tr_valid); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_stats got %b/%0d required 0/0", overflow, drop_cnt); end
        halt = 1;
        exp_q.push_back(16'hF000); exp_q.push_back(cyc[31:16]); exp_q.push_back(cyc[15:0]);
        step();
        clear_inputs();
        wait_drain(ok);
        checks++; if (!ok || done !== 1'b1) begin errors++; $display("[TB] FAIL mid_halt_after got %0d/%b required 0/1", exp_q.size(), done); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        step();
        test_reg_write();
        test_back_to_back();
        test_overflow();
        test_priority();
        test_stall();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
